// File: rtl/swt16_hazard_ctrl_pkg.sv
// Shared definitions for the swt16 pipeline sequencing controller:
// FSM state encoding, default register index width, bubble NOP encoding.
package swt16_pkg;

    typedef logic [1:0] state_t;

    localparam state_t INIT  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t STALL = 2'd2;
    localparam state_t FLUSH = 2'd3;

    localparam int REG_IDX_WIDTH_DEF = 4;

    // Instruction word injected into DC/EX when a bubble is requested.
    localparam logic [15:0] NOP_INSN = 16'h0000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/swt16_hazard_ctrl_if.sv
// Decode/EX/writeback hazard bus between the pipeline and the controller.
// slave: controller side (takes in_*, drives out_*); master: pipeline side.
// Optional out_stall_cnt/out_flush_cnt exist with SWT16_HAZARD_PERF_EN.
interface swt16_hazard_ctrl_if
    import swt16_pkg::*;
#(
    parameter int REG_IDX_WIDTH = REG_IDX_WIDTH_DEF
);
    logic                     in_dc_valid;
    logic [REG_IDX_WIDTH-1:0] in_dc_src1_idx;
    logic                     in_dc_src1_rd;
    logic [REG_IDX_WIDTH-1:0] in_dc_src2_idx;
    logic                     in_dc_src2_rd;
    logic [REG_IDX_WIDTH-1:0] in_dc_dst_idx;
    logic                     in_dc_dst_wr;
    logic                     in_ex_set_pc;
    logic                     in_wb_valid;
    logic [REG_IDX_WIDTH-1:0] in_wb_dst_idx;
    logic                     out_stall_if;
    logic                     out_stall_dc;
    logic                     out_bubble_ex;
    logic                     out_flush;
    logic                     out_issue;
    logic                     out_busy;
    logic                     out_err;
`ifdef SWT16_HAZARD_PERF_EN
    logic [15:0]              out_stall_cnt;
    logic [15:0]              out_flush_cnt;
`endif

    modport slave (
        input  in_dc_valid, in_dc_src1_idx, in_dc_src1_rd,
        input  in_dc_src2_idx, in_dc_src2_rd,
        input  in_dc_dst_idx, in_dc_dst_wr,
        input  in_ex_set_pc, in_wb_valid, in_wb_dst_idx,
`ifdef SWT16_HAZARD_PERF_EN
        output out_stall_cnt, out_flush_cnt,
`endif
        output out_stall_if, out_stall_dc, out_bubble_ex,
        output out_flush, out_issue, out_busy, out_err
    );

    modport master (
        output in_dc_valid, in_dc_src1_idx, in_dc_src1_rd,
        output in_dc_src2_idx, in_dc_src2_rd,
        output in_dc_dst_idx, in_dc_dst_wr,
        output in_ex_set_pc, in_wb_valid, in_wb_dst_idx,
`ifdef SWT16_HAZARD_PERF_EN
        input  out_stall_cnt, out_flush_cnt,
`endif
        input  out_stall_if, out_stall_dc, out_bubble_ex,
        input  out_flush, out_issue, out_busy, out_err
    );

endinterface

// File: rtl/swt16_hazard_ctrl_scoreboard.sv
// Per-register pending-write counters with issue increment, writeback
// decrement, sticky underflow error and three pending lookups.
module swt16_scoreboard
    import swt16_pkg::*;
#(
    parameter int REG_IDX_WIDTH = REG_IDX_WIDTH_DEF,
    parameter int CNT_WIDTH     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue,
    input  logic                     dst_wr,
    input  logic [REG_IDX_WIDTH-1:0] dst_idx,
    input  logic                     wb_valid,
    input  logic [REG_IDX_WIDTH-1:0] wb_dst_idx,
    input  logic [REG_IDX_WIDTH-1:0] src1_idx,
    input  logic [REG_IDX_WIDTH-1:0] src2_idx,
    output logic                     src1_pend,
    output logic                     src2_pend,
    output logic                     dst_full,
    output logic                     busy,
    output logic                     err
);
    localparam int NREG = 1 << REG_IDX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q [NREG];
    logic [CNT_WIDTH-1:0] cnt_d [NREG];
    logic [NREG-1:0]      inc_v;
    logic [NREG-1:0]      dec_v;
    logic                 err_q;
    logic                 err_d;

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        inc_v[dst_idx]    = issue & dst_wr;
        dec_v[wb_dst_idx] = wb_valid;
    end

    always_comb begin
        err_d = err_q;
        if (wb_valid && cnt_q[wb_dst_idx] == '0)
            err_d = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_v[i] && !dec_v[i])
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (dec_v[i] && !inc_v[i] && cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            for (int i = 0; i < NREG; i++)
                cnt_q[i] <= '0;
        end else begin
            err_q <= err_d;
            for (int i = 0; i < NREG; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NREG; i++)
            busy = busy | (cnt_q[i] != '0);
    end

    assign src1_pend = cnt_q[src1_idx] != '0;
    assign src2_pend = cnt_q[src2_idx] != '0;
    assign dst_full  = cnt_q[dst_idx] == CNT_MAX;
    assign err       = err_q;

endmodule

// File: rtl/swt16_hazard_ctrl.sv
// swt16 IF/DC/EX sequencing controller: RAW/structural stall, redirect
// flush sequence and post-reset fetch hold. Ports: clock, reset (async,
// active-low), bus (swt16_hazard_ctrl_if.slave). Optional perf counters
// out_stall_cnt/out_flush_cnt are enabled by SWT16_HAZARD_PERF_EN.
module swt16_hazard_ctrl
    import swt16_pkg::*;
#(
    parameter int REG_IDX_WIDTH = REG_IDX_WIDTH_DEF,
    parameter int CNT_WIDTH     = 2,
    parameter int FLUSH_CYCLES  = 2,
    parameter int INIT_CYCLES   = 1
) (
    input logic                clock,
    input logic                reset,
    swt16_hazard_ctrl_if.slave bus
);
    localparam int TMAX = (INIT_CYCLES > FLUSH_CYCLES) ? INIT_CYCLES : FLUSH_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [TW-1:0] T_INIT  = TW'(INIT_CYCLES);
    localparam logic [TW-1:0] T_FLUSH = TW'(FLUSH_CYCLES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          src1_pend, src2_pend, dst_full;
    logic          hazard, issue;

    assign hazard = bus.in_dc_valid &
                    ((bus.in_dc_src1_rd & src1_pend) |
                     (bus.in_dc_src2_rd & src2_pend) |
                     (bus.in_dc_dst_wr  & dst_full));

    assign issue = ((state_q == RUN) || (state_q == STALL)) &
                   bus.in_dc_valid & ~hazard & ~bus.in_ex_set_pc;

    swt16_scoreboard #(
        .REG_IDX_WIDTH (REG_IDX_WIDTH),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_sb (
        .clock      (clock),
        .reset      (reset),
        .issue      (issue),
        .dst_wr     (bus.in_dc_dst_wr),
        .dst_idx    (bus.in_dc_dst_idx),
        .wb_valid   (bus.in_wb_valid),
        .wb_dst_idx (bus.in_wb_dst_idx),
        .src1_idx   (bus.in_dc_src1_idx),
        .src2_idx   (bus.in_dc_src2_idx),
        .src1_pend  (src1_pend),
        .src2_pend  (src2_pend),
        .dst_full   (dst_full),
        .busy       (bus.out_busy),
        .err        (bus.out_err)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            tmr_q   <= T_INIT;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // The redirect cycle itself flushes, so FLUSH covers the remaining
    // FLUSH_CYCLES-1 cycles; with a single flush cycle FLUSH is skipped.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            INIT: begin
                if (tmr_q <= T_ONE) state_d = RUN;
                else                tmr_d   = tmr_q - T_ONE;
            end
            RUN, STALL: begin
                if (bus.in_ex_set_pc) begin
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    tmr_d   = T_FLUSH;
                end else begin
                    state_d = hazard ? STALL : RUN;
                end
            end
            FLUSH: begin
                if (bus.in_ex_set_pc) begin
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    tmr_d   = T_FLUSH;
                end else if (tmr_q <= T_ONE) begin
                    state_d = RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d   = tmr_q - T_ONE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        bus.out_stall_if  = 1'b0;
        bus.out_stall_dc  = 1'b0;
        bus.out_bubble_ex = 1'b0;
        bus.out_flush     = 1'b0;
        bus.out_issue     = issue;
        unique case (state_q)
            INIT: begin
                bus.out_stall_if  = 1'b1;
                bus.out_stall_dc  = 1'b1;
                bus.out_bubble_ex = 1'b1;
            end
            RUN, STALL: begin
                if (bus.in_ex_set_pc) begin
                    bus.out_flush     = 1'b1;
                    bus.out_bubble_ex = 1'b1;
                end else if (hazard) begin
                    bus.out_stall_if  = 1'b1;
                    bus.out_stall_dc  = 1'b1;
                    bus.out_bubble_ex = 1'b1;
                end
            end
            FLUSH: begin
                bus.out_flush     = 1'b1;
                bus.out_bubble_ex = 1'b1;
            end
            default: begin
                bus.out_stall_if  = 1'b1;
                bus.out_stall_dc  = 1'b1;
                bus.out_bubble_ex = 1'b1;
            end
        endcase
    end

`ifdef SWT16_HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = (state_q == STALL) ? sat_inc16(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = (state_q == FLUSH) ? sat_inc16(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.out_stall_cnt = stall_cnt_q;
    assign bus.out_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_swt16_hazard_ctrl.sv
// Directed self-checking bench for swt16_hazard_ctrl (4-bit indices,
// 2-bit counters, FLUSH_CYCLES=2, INIT_CYCLES=1).
module tb_swt16_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    swt16_hazard_ctrl_if #(.REG_IDX_WIDTH(4)) bus ();

    swt16_hazard_ctrl #(
        .REG_IDX_WIDTH (4),
        .CNT_WIDTH     (2),
        .FLUSH_CYCLES  (2),
        .INIT_CYCLES   (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic idle();
        bus.in_dc_valid    = 1'b0;
        bus.in_dc_src1_idx = '0;
        bus.in_dc_src1_rd  = 1'b0;
        bus.in_dc_src2_idx = '0;
        bus.in_dc_src2_rd  = 1'b0;
        bus.in_dc_dst_idx  = '0;
        bus.in_dc_dst_wr   = 1'b0;
        bus.in_ex_set_pc   = 1'b0;
        bus.in_wb_valid    = 1'b0;
        bus.in_wb_dst_idx  = '0;
    endtask

    task automatic dc_write(input logic [3:0] d);
        bus.in_dc_valid   = 1'b1;
        bus.in_dc_dst_wr  = 1'b1;
        bus.in_dc_dst_idx = d;
        bus.in_dc_src1_rd = 1'b0;
    endtask

    task automatic dc_read(input logic [3:0] s);
        bus.in_dc_valid    = 1'b1;
        bus.in_dc_dst_wr   = 1'b0;
        bus.in_dc_src1_rd  = 1'b1;
        bus.in_dc_src1_idx = s;
    endtask

    task automatic test_reset();
        idle();
        bus.in_dc_valid = 1'b1;
        reset = 1'b0;
        @(negedge clock); #1;
        n_run++;
        if ({bus.out_stall_if, bus.out_stall_dc, bus.out_bubble_ex} !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_stalls got %b exp 111",
                     {bus.out_stall_if, bus.out_stall_dc, bus.out_bubble_ex});
        end
        n_run++;
        if ({bus.out_flush, bus.out_issue, bus.out_busy, bus.out_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_misc got %b exp 0000",
                     {bus.out_flush, bus.out_issue, bus.out_busy, bus.out_err});
        end
        @(negedge clock);
        idle();
        reset = 1'b1;
        #1;
        n_run++;
        if (bus.out_stall_if !== 1'b1) begin
            n_fail++;
            $display("FAIL init_hold got %b exp 1", bus.out_stall_if);
        end
        @(negedge clock); #1;
        n_run++;
        if ({bus.out_stall_if, bus.out_stall_dc, bus.out_bubble_ex, bus.out_flush} !== 4'b0000) begin
            n_fail++;
            $display("FAIL run_ctrl got %b exp 0000",
                     {bus.out_stall_if, bus.out_stall_dc, bus.out_bubble_ex, bus.out_flush});
        end
    endtask

    task automatic test_raw();
        @(negedge clock); idle(); dc_write(4'd3); #1;
        n_run++;
        if (bus.out_issue !== 1'b1) begin
            n_fail++; $display("FAIL raw_issue_w got %b exp 1", bus.out_issue);
        end
        @(negedge clock); dc_read(4'd3); #1;
        n_run++;
        if ({bus.out_stall_dc, bus.out_bubble_ex, bus.out_issue, bus.out_busy} !== 4'b1101) begin
            n_fail++;
            $display("FAIL raw_stall got %b exp 1101",
                     {bus.out_stall_dc, bus.out_bubble_ex, bus.out_issue, bus.out_busy});
        end
        @(negedge clock); #1;
        n_run++;
        if (bus.out_stall_if !== 1'b1) begin
            n_fail++; $display("FAIL raw_hold_if got %b exp 1", bus.out_stall_if);
        end
        @(negedge clock);
        bus.in_wb_valid = 1'b1; bus.in_wb_dst_idx = 4'd3; #1;
        n_run++;
        if ({bus.out_stall_dc, bus.out_issue} !== 2'b10) begin
            n_fail++;
            $display("FAIL raw_wb_same got %b exp 10", {bus.out_stall_dc, bus.out_issue});
        end
        @(negedge clock); bus.in_wb_valid = 1'b0; #1;
        n_run++;
        if ({bus.out_issue, bus.out_stall_dc, bus.out_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL raw_release got %b exp 100",
                     {bus.out_issue, bus.out_stall_dc, bus.out_busy});
        end
        @(negedge clock); idle(); #1;
        n_run++;
        if (bus.out_stall_if !== 1'b0) begin
            n_fail++; $display("FAIL raw_run got %b exp 0", bus.out_stall_if);
        end
`ifdef SWT16_HAZARD_PERF_EN
        n_run++;
        if (bus.out_stall_cnt !== 16'd3) begin
            n_fail++; $display("FAIL perf_stall got %0d exp 3", bus.out_stall_cnt);
        end
`endif
    endtask

    task automatic test_structural();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); idle(); dc_write(4'd5); #1;
            n_run++;
            if (bus.out_issue !== 1'b1) begin
                n_fail++; $display("FAIL str_issue%0d got %b exp 1", i, bus.out_issue);
            end
        end
        @(negedge clock); #1;
        n_run++;
        if ({bus.out_stall_dc, bus.out_issue} !== 2'b10) begin
            n_fail++;
            $display("FAIL str_full got %b exp 10", {bus.out_stall_dc, bus.out_issue});
        end
        @(negedge clock);
        bus.in_wb_valid = 1'b1; bus.in_wb_dst_idx = 4'd5; #1;
        n_run++;
        if (bus.out_stall_dc !== 1'b1) begin
            n_fail++; $display("FAIL str_wb_same got %b exp 1", bus.out_stall_dc);
        end
        @(negedge clock); bus.in_wb_valid = 1'b0; #1;
        n_run++;
        if (bus.out_issue !== 1'b1) begin
            n_fail++; $display("FAIL str_issue4 got %b exp 1", bus.out_issue);
        end
        @(negedge clock); idle(); #1;
        n_run++;
        if (dut.u_sb.cnt_q[5] !== 2'd3) begin
            n_fail++; $display("FAIL str_cnt5 got %0d exp 3", dut.u_sb.cnt_q[5]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); bus.in_wb_valid = 1'b1; bus.in_wb_dst_idx = 4'd5;
        end
        @(negedge clock); idle(); #1;
        n_run++;
        if ({bus.out_busy, bus.out_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL str_drain got %b exp 00", {bus.out_busy, bus.out_err});
        end
    endtask

    task automatic test_flush();
        @(negedge clock); idle(); dc_write(4'd3);
        @(negedge clock); dc_read(4'd3); #1;
        n_run++;
        if (bus.out_stall_dc !== 1'b1) begin
            n_fail++; $display("FAIL fl_stall got %b exp 1", bus.out_stall_dc);
        end
        @(negedge clock); bus.in_ex_set_pc = 1'b1; #1;
        n_run++;
        if ({bus.out_flush, bus.out_bubble_ex, bus.out_stall_dc, bus.out_issue} !== 4'b1100) begin
            n_fail++;
            $display("FAIL fl_first got %b exp 1100",
                     {bus.out_flush, bus.out_bubble_ex, bus.out_stall_dc, bus.out_issue});
        end
        @(negedge clock); idle(); dc_write(4'd9); #1;
        n_run++;
        if ({bus.out_flush, bus.out_issue} !== 2'b10) begin
            n_fail++;
            $display("FAIL fl_second got %b exp 10", {bus.out_flush, bus.out_issue});
        end
        @(negedge clock); idle(); #1;
        n_run++;
        if (bus.out_flush !== 1'b0) begin
            n_fail++; $display("FAIL fl_end got %b exp 0", bus.out_flush);
        end
        n_run++;
        if ({dut.u_sb.cnt_q[3], dut.u_sb.cnt_q[9]} !== 4'b0100) begin
            n_fail++;
            $display("FAIL fl_cnts got %b exp 0100", {dut.u_sb.cnt_q[3], dut.u_sb.cnt_q[9]});
        end
        @(negedge clock); bus.in_ex_set_pc = 1'b1;
        @(negedge clock); #1;
        n_run++;
        if (bus.out_flush !== 1'b1) begin
            n_fail++; $display("FAIL ff_reload got %b exp 1", bus.out_flush);
        end
        @(negedge clock); bus.in_ex_set_pc = 1'b0; #1;
        n_run++;
        if (bus.out_flush !== 1'b1) begin
            n_fail++; $display("FAIL ff_tail got %b exp 1", bus.out_flush);
        end
        @(negedge clock); #1;
        n_run++;
        if (bus.out_flush !== 1'b0) begin
            n_fail++; $display("FAIL ff_end got %b exp 0", bus.out_flush);
        end
        bus.in_wb_valid = 1'b1; bus.in_wb_dst_idx = 4'd3;
        @(negedge clock); idle(); #1;
        n_run++;
        if (bus.out_busy !== 1'b0) begin
            n_fail++; $display("FAIL fl_drain got %b exp 0", bus.out_busy);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clock); idle(); dc_write(4'd2);
        @(negedge clock);
        bus.in_wb_valid = 1'b1; bus.in_wb_dst_idx = 4'd2; #1;
        n_run++;
        if (bus.out_issue !== 1'b1) begin
            n_fail++; $display("FAIL sc_issue got %b exp 1", bus.out_issue);
        end
        @(negedge clock); idle(); #1;
        n_run++;
        if (dut.u_sb.cnt_q[2] !== 2'd1) begin
            n_fail++; $display("FAIL sc_cnt2 got %0d exp 1", dut.u_sb.cnt_q[2]);
        end
        bus.in_wb_valid = 1'b1; bus.in_wb_dst_idx = 4'd2;
        @(negedge clock); idle(); #1;
        n_run++;
        if ({bus.out_busy, bus.out_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL sc_drain got %b exp 00", {bus.out_busy, bus.out_err});
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clock); idle(); dc_write(4'd7);
        @(negedge clock); dc_read(4'd7);
        #2; reset = 1'b0; #1;
        n_run++;
        if ({bus.out_stall_if, bus.out_busy, bus.out_issue} !== 3'b100) begin
            n_fail++;
            $display("FAIL mr_reset got %b exp 100",
                     {bus.out_stall_if, bus.out_busy, bus.out_issue});
        end
        @(negedge clock);
        idle(); reset = 1'b1; bus.in_ex_set_pc = 1'b1; #1;
        n_run++;
        if ({bus.out_flush, bus.out_stall_if} !== 2'b01) begin
            n_fail++;
            $display("FAIL mr_init_pc got %b exp 01", {bus.out_flush, bus.out_stall_if});
        end
        @(negedge clock);
        idle(); bus.in_wb_valid = 1'b1; bus.in_wb_dst_idx = 4'd7; #1;
        n_run++;
        if ({bus.out_flush, bus.out_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL mr_run got %b exp 00", {bus.out_flush, bus.out_err});
        end
        @(negedge clock); idle(); #1;
        n_run++;
        if ({bus.out_err, dut.u_sb.cnt_q[7]} !== 3'b100) begin
            n_fail++;
            $display("FAIL err_set got %b exp 100", {bus.out_err, dut.u_sb.cnt_q[7]});
        end
        repeat (3) @(negedge clock);
        #1;
        n_run++;
        if (bus.out_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got %b exp 1", bus.out_err);
        end
        reset = 1'b0; #1;
        n_run++;
        if (bus.out_err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear got %b exp 0", bus.out_err);
        end
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_raw();
        test_structural();
        test_flush();
        test_same_cycle();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
